// File: rtl/pipe_stage_reg_pkg.sv
// Shared encodings for inter-stage pipeline registers: the NOP control pattern
// and the field offsets stages use to pack/unpack the payload bus.
package pipe_stage_reg_pkg;

    localparam int ALUOP_W    = 8;
    localparam int ALUSEL_W   = 3;
    localparam int REG_ADDR_W = 5;

    localparam logic [ALUOP_W-1:0]    EXE_NOP_OP    = 8'b0000_0000;
    localparam logic [ALUSEL_W-1:0]   EXE_RES_NOP   = 3'b000;
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR  = 5'b00000;
    localparam logic                  WRITE_DISABLE = 1'b0;

    // Control fields sit at the bottom of the payload, LSB first.
    localparam int ALUOP_LSB  = 0;
    localparam int ALUSEL_LSB = ALUOP_LSB + ALUOP_W;
    localparam int WD_LSB     = ALUSEL_LSB + ALUSEL_W;
    localparam int WREG_LSB   = WD_LSB + REG_ADDR_W;
    localparam int CTRL_W     = WREG_LSB + 1;

    localparam logic [CTRL_W-1:0] NOP_CTRL = {WRITE_DISABLE, NOP_REG_ADDR,
                                              EXE_RES_NOP, EXE_NOP_OP};

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_MAIN  = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry FIFO core for a pipeline stage: main entry drives the outputs,
// skid entry absorbs one beat under backpressure; ready comes from a flop.
//
// state      | meaning
// SKID_EMPTY | no beat held, out valid low
// SKID_MAIN  | main entry holds a beat, skid entry empty
// SKID_FULL  | main and skid both hold beats, ready low
module pipe_skid_buf
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop_ready,
    output logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    skid_state_e       state;
    skid_state_e       state_nxt;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              ready_q;
    logic              pop;
    logic              main_load_in;
    logic              main_load_skid;
    logic              skid_load;

    assign valid = (state != SKID_EMPTY);
    assign pop   = valid & pop_ready;
    assign ready = ready_q;
    assign data  = main_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= SKID_EMPTY;
            ready_q <= 1'b1;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt != SKID_FULL);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (main_load_in) begin
                main_q <= push_data;
            end else if (main_load_skid) begin
                main_q <= skid_q;
            end
            if (skid_load) begin
                skid_q <= push_data;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        main_load_in   = 1'b0;
        main_load_skid = 1'b0;
        skid_load      = 1'b0;
        if (clear) begin
            state_nxt = SKID_EMPTY;
        end else begin
            case (state)
                SKID_EMPTY: begin
                    if (push) begin
                        state_nxt    = SKID_MAIN;
                        main_load_in = 1'b1;
                    end
                end
                SKID_MAIN: begin
                    if (push && pop) begin
                        main_load_in = 1'b1;
                    end else if (push) begin
                        state_nxt = SKID_FULL;
                        skid_load = 1'b1;
                    end else if (pop) begin
                        state_nxt = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    // ready is low here, so no push can arrive alongside the pop
                    if (pop) begin
                        state_nxt      = SKID_MAIN;
                        main_load_skid = 1'b1;
                    end
                end
                default: begin
                    state_nxt = SKID_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional skid
// entry, flush with post-flush drop of wrong-path beats, and a beat counter.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W  = 64,
    parameter bit                SKID    = 1'b1,
    parameter int                DROP_W  = 2,
    parameter int                CNT_W   = 32,
    parameter logic [DATA_W-1:0] NOP_VAL = DATA_W'(NOP_CTRL)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic [DROP_W-1:0] flush_drop,
    output logic              drop_busy,
    output logic [CNT_W-1:0]  perf_cnt
);

    logic [DROP_W-1:0] drop_q;
    logic [CNT_W-1:0]  perf_q;
    logic              drop_active;
    logic              accept;
    logic              store;
    logic              deliver;
    logic              core_ready;
    logic              core_valid;
    logic [DATA_W-1:0] core_data;

    assign drop_active = (drop_q != '0);
    assign in_ready    = drop_active | core_ready;
    assign accept      = in_valid & in_ready;
    // wrong-path beats are taken off the wire but never stored
    assign store       = accept & ~drop_active & ~flush;
    assign out_valid   = core_valid;
    assign out_data    = core_valid ? core_data : NOP_VAL;
    assign deliver     = out_valid & out_ready;
    assign drop_busy   = drop_active;
    assign perf_cnt    = perf_q;

    generate
        if (SKID) begin : g_skid
            pipe_skid_buf #(
                .DATA_W (DATA_W)
            ) u_skid (
                .clk       (clk),
                .rst       (rst),
                .clear     (flush),
                .push      (store),
                .push_data (in_data),
                .pop_ready (out_ready),
                .ready     (core_ready),
                .valid     (core_valid),
                .data      (core_data)
            );
        end else begin : g_single
            logic              entry_v;
            logic [DATA_W-1:0] entry_d;

            assign core_ready = ~entry_v | out_ready;
            assign core_valid = entry_v;
            assign core_data  = entry_d;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    entry_v <= 1'b0;
                    entry_d <= '0;
                end else if (flush) begin
                    entry_v <= 1'b0;
                end else if (store) begin
                    entry_v <= 1'b1;
                    entry_d <= in_data;
                end else if (out_ready) begin
                    entry_v <= 1'b0;
                end
            end
        end
    endgenerate

    // A flush reloads rather than adds, so a re-flush restarts the drop window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_q <= '0;
        end else if (flush) begin
            drop_q <= flush_drop;
        end else if (drop_active && in_valid) begin
            drop_q <= drop_q - DROP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_q <= '0;
        end else if (deliver && !flush && !(&perf_q)) begin
            perf_q <= perf_q + CNT_W'(1);
        end
    end

endmodule
